// File: rtl/spi_slave.sv
// SPI mode-0 slave: synchronizes the master's pins into the sclk domain, shifts bytes
// in and out, and double-buffers transmit data so multi-byte frames stream without gaps.
`timescale 1ns/1ps
module spi_slave #(
  parameter int DATA_W = 8
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              SPI_SCLK,
  input  logic              SPI_CSN,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {WAIT, IDLE, ACTIVE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        sck_sync_q, sck_sync_d;
  logic [2:0]        csn_sync_q, csn_sync_d;
  logic [1:0]        mosi_sync_q, mosi_sync_d;
  logic [1:0]        flush_q, flush_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic              tx_ready_q, tx_ready_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;

  logic              sck_rise, sck_fall, csn_rise, csn_fall, buf_load;
  logic [DATA_W-1:0] buf_data;

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state_q     <= WAIT;
      sck_sync_q  <= '0;
      csn_sync_q  <= '1;
      mosi_sync_q <= '0;
      flush_q     <= '0;
      cnt_q       <= '0;
      wrap_q      <= 1'b0;
      tx_buf_q    <= '0;
      tx_ready_q  <= 1'b1;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      csn_sync_q  <= csn_sync_d;
      mosi_sync_q <= mosi_sync_d;
      flush_q     <= flush_d;
      cnt_q       <= cnt_d;
      wrap_q      <= wrap_d;
      tx_buf_q    <= tx_buf_d;
      tx_ready_q  <= tx_ready_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], SPI_SCLK};
    csn_sync_d  = {csn_sync_q[1:0], SPI_CSN};
    mosi_sync_d = {mosi_sync_q[0], SPI_MOSI};

    sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    csn_rise = csn_sync_q[1] & ~csn_sync_q[2];
    csn_fall = ~csn_sync_q[1] & csn_sync_q[2];
    buf_data = tx_ready_q ? '0 : tx_buf_q;

    state_d     = state_q;
    flush_d     = (flush_q == 2'd2) ? flush_q : flush_q + 2'd1;
    cnt_d       = cnt_q;
    wrap_d      = wrap_q;
    tx_buf_d    = tx_buf_q;
    tx_ready_d  = tx_ready_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    buf_load    = 1'b0;

    case (state_q)
      // The synchronizers come out of reset at the idle level, so CSN is only trusted
      // once the real pin value has propagated through both stages.
      WAIT: begin
        if (flush_q == 2'd2 && csn_sync_q[1]) state_d = IDLE;
      end
      IDLE: begin
        if (csn_fall) begin
          state_d  = ACTIVE;
          tx_sh_d  = buf_data;
          buf_load = 1'b1;
          cnt_d    = '0;
          wrap_d   = 1'b0;
        end
      end
      ACTIVE: begin
        if (csn_rise) begin
          state_d     = IDLE;
          frame_err_d = (cnt_q != '0);
          wrap_d      = 1'b0;
        end else begin
          if (sck_rise) begin
            rx_sh_d = {rx_sh_q[DATA_W-2:0], mosi_sync_q[1]};
            if (cnt_q == CNT_LAST) begin
              cnt_d      = '0;
              wrap_d     = 1'b1;
              rx_data_d  = {rx_sh_q[DATA_W-2:0], mosi_sync_q[1]};
              rx_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          // The fall after the last bit hands the next buffered byte straight to MISO.
          if (sck_fall) begin
            if (wrap_q) begin
              tx_sh_d  = buf_data;
              buf_load = 1'b1;
              wrap_d   = 1'b0;
            end else begin
              tx_sh_d = tx_sh_q << 1;
            end
          end
        end
      end
      default: state_d = WAIT;
    endcase

    if (buf_load) begin
      tx_ready_d = 1'b1;
    end else if (tx_load && tx_ready_q) begin
      tx_buf_d   = tx_data;
      tx_ready_d = 1'b0;
    end
  end

  assign SPI_MISO  = (state_q == ACTIVE) & tx_sh_q[DATA_W-1];
  assign busy      = (state_q == ACTIVE);
  assign tx_ready  = tx_ready_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a table of single-byte frames plus hand-built
// sequences for streaming, aborted frames, buffer overwrite and mid-frame reset.
`timescale 1ns/1ps
module tb_spi_slave;

  localparam int HP = 6;

  logic       sclk = 1'b0;
  logic       rst_n;
  logic       SPI_SCLK, SPI_CSN, SPI_MOSI, SPI_MISO;
  logic [7:0] tx_data;
  logic       tx_load, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy;

  int nvec = 0;
  int nerr = 0;
  int rxv_cnt = 0;
  int ferr_cnt = 0;
  logic [7:0] rxq[$];

  spi_slave #(.DATA_W(8)) dut (
    .sclk(sclk), .rst_n(rst_n),
    .SPI_SCLK(SPI_SCLK), .SPI_CSN(SPI_CSN), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 sclk = ~sclk;

  always @(negedge sclk) begin
    if (rx_valid) begin
      rxv_cnt++;
      rxq.push_back(rx_data);
    end
    if (frame_err) ferr_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       load;
    logic [7:0] txb;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic tx_put(input logic [7:0] b);
    @(negedge sclk);
    tx_data = b;
    tx_load = 1'b1;
    @(negedge sclk);
    tx_load = 1'b0;
    cyc(1);
  endtask

  task automatic frame_begin();
    SPI_CSN = 1'b0;
    cyc(8);
  endtask

  task automatic frame_end();
    cyc(8);
    SPI_CSN = 1'b1;
    cyc(8);
  endtask

  task automatic spi_xfer(input logic [7:0] mo, input int nb, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nb; i++) begin
      SPI_MOSI = mo[7-i];
      cyc(HP);
      SPI_SCLK = 1'b1;
      mi = {mi[6:0], SPI_MISO};
      cyc(HP);
      SPI_SCLK = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] mi, mi2;
    int rx0, fe0;

    vecs[0] = '{1'b1, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
    vecs[1] = '{1'b0, 8'h00, 8'h5A, 8'h00, 8'h5A};
    vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[3] = '{1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};
    vecs[4] = '{1'b1, 8'hC3, 8'h0F, 8'hC3, 8'h0F};

    rst_n = 1'b0; SPI_SCLK = 1'b0; SPI_CSN = 1'b1; SPI_MOSI = 1'b0;
    tx_data = 8'h00; tx_load = 1'b0;
    cyc(3);
    chk("reset tx_ready", tx_ready, 1);
    chk("reset rx_data", rx_data, 8'h00);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset busy", busy, 0);
    chk("reset miso", SPI_MISO, 0);
    rst_n = 1'b1;
    cyc(6);

    // Table of single-byte frames
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].load) begin
        tx_put(vecs[v].txb);
        chk($sformatf("v%0d tx_ready after load", v), tx_ready, 0);
      end
      rx0 = rxv_cnt; fe0 = ferr_cnt;
      frame_begin();
      chk($sformatf("v%0d tx_ready after csn fall", v), tx_ready, 1);
      chk($sformatf("v%0d busy", v), busy, 1);
      spi_xfer(vecs[v].mosi, 8, mi);
      frame_end();
      chk($sformatf("v%0d miso byte", v), mi, vecs[v].exp_miso);
      chk($sformatf("v%0d rx_valid pulses", v), rxv_cnt - rx0, 1);
      chk($sformatf("v%0d rx_data", v), rx_data, vecs[v].exp_rx);
      chk($sformatf("v%0d frame_err pulses", v), ferr_cnt - fe0, 0);
      chk($sformatf("v%0d busy after frame", v), busy, 0);
    end

    // 16-bit frame: second byte buffered while the first is in flight
    tx_put(8'h56);
    rxq.delete();
    rx0 = rxv_cnt;
    frame_begin();
    chk("stream tx_ready after fall", tx_ready, 1);
    tx_put(8'h78);
    chk("stream tx_ready after 2nd load", tx_ready, 0);
    spi_xfer(8'h12, 8, mi);
    spi_xfer(8'h34, 8, mi2);
    frame_end();
    chk("stream miso byte0", mi, 8'h56);
    chk("stream miso byte1", mi2, 8'h78);
    chk("stream rx_valid pulses", rxv_cnt - rx0, 2);
    chk("stream rx count", rxq.size(), 2);
    if (rxq.size() == 2) begin
      chk("stream rx byte0", rxq[0], 8'h12);
      chk("stream rx byte1", rxq[1], 8'h34);
    end
    chk("stream tx_ready end", tx_ready, 1);

    // Aborted frame after three bits
    rx0 = rxv_cnt; fe0 = ferr_cnt;
    frame_begin();
    spi_xfer(8'hE7, 3, mi);
    frame_end();
    chk("abort frame_err pulses", ferr_cnt - fe0, 1);
    chk("abort rx_valid pulses", rxv_cnt - rx0, 0);
    chk("abort rx_data held", rx_data, 8'h34);
    chk("abort busy", busy, 0);

    // Second load while the buffer is full is dropped
    tx_put(8'h11);
    tx_put(8'h22);
    chk("overwrite tx_ready", tx_ready, 0);
    frame_begin();
    spi_xfer(8'hC9, 8, mi);
    frame_end();
    chk("overwrite miso", mi, 8'h11);
    chk("overwrite rx_data", rx_data, 8'hC9);

    // Reset mid-byte with CSN held low
    tx_put(8'hAA);
    rx0 = rxv_cnt; fe0 = ferr_cnt;
    frame_begin();
    spi_xfer(8'hF0, 4, mi);
    rst_n = 1'b0;
    cyc(2);
    chk("midrst miso in reset", SPI_MISO, 0);
    chk("midrst busy in reset", busy, 0);
    rst_n = 1'b1;
    cyc(2);
    chk("midrst tx_ready", tx_ready, 1);
    chk("midrst rx_data", rx_data, 8'h00);
    spi_xfer(8'hFF, 4, mi);
    cyc(8);
    chk("midrst busy stays low", busy, 0);
    chk("midrst miso stays low", SPI_MISO, 0);
    SPI_CSN = 1'b1;
    cyc(8);
    chk("midrst rx_valid pulses", rxv_cnt - rx0, 0);
    chk("midrst frame_err pulses", ferr_cnt - fe0, 0);
    tx_put(8'h96);
    rx0 = rxv_cnt;
    frame_begin();
    chk("postrst busy", busy, 1);
    spi_xfer(8'h69, 8, mi);
    frame_end();
    chk("postrst miso", mi, 8'h96);
    chk("postrst rx_data", rx_data, 8'h69);
    chk("postrst rx_valid pulses", rxv_cnt - rx0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 8, frame width in bits; only 8 is required to be supported.
REQ-002 SHALL have port sclk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port SPI_SCLK  input  1  serial clock from master, asynchronous to sclk, idle low.
REQ-005 SHALL have port SPI_CSN  input  1  chip select from master, active-low, asynchronous.
REQ-006 SHALL have port SPI_MOSI  input  1  serial data from master, MSB first.
REQ-007 SHALL have port SPI_MISO  output  1  serial data to master, MSB first.
REQ-008 SHALL have port tx_data  input  8  byte offered for the next transmit slot.
REQ-009 SHALL have port tx_load  input  1  write strobe for tx_data; accepted only when tx_ready=1.
REQ-010 SHALL have port tx_ready  output  1  transmit buffer empty.
REQ-011 SHALL have port rx_data  output  8  last complete received byte; held until the next byte completes.
REQ-012 SHALL have port rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse, CSN deasserted mid-byte.
REQ-014 SHALL have port busy  output  1  high in state ACTIVE.

Function
REQ-015 SHALL use SPI mode 0: sample MOSI on SCLK rise, update MISO on SCLK fall.
REQ-016 SHALL pass SPI_SCLK, SPI_CSN and SPI_MOSI through 2-FF synchronizers plus one edge-detect register; edges are detected on the synchronized values.
REQ-017 SHALL require SCLK high and low phases of at least 3 sclk cycles each, and CSN fall at least 3 sclk cycles before the first SCLK rise; behaviour outside these limits is undefined.
REQ-018 SHALL implement states WAIT, IDLE and ACTIVE.
- WAIT: entered on reset; moves to IDLE once synchronized CSN is 1.
- IDLE: moves to ACTIVE on a detected CSN fall.
- ACTIVE: moves to IDLE on a detected CSN rise.
REQ-019 SHALL, on the CSN fall, load the tx shift register from the tx buffer (0x00 if empty), set tx_ready=1 the next cycle, and clear the 3-bit bit counter.
REQ-020 SHALL drive SPI_MISO from tx shift register bit 7 in ACTIVE, and 0 otherwise.
REQ-021 SHALL, on each SCLK rise in ACTIVE, shift synchronized MOSI into the rx shift register LSB and increment the bit counter, wrapping 7->0.
REQ-022 SHALL, when the counter wraps (8th rise), register rx_data and pulse rx_valid in the cycle immediately following the edge-detect cycle.
REQ-023 SHALL, on each SCLK fall in ACTIVE, shift the tx register left by one. If the fall follows a counter wrap, it SHALL instead reload the register from the tx buffer (0x00 if empty) and set tx_ready=1, so that multi-byte frames stream back to back.
REQ-024 SHALL capture tx_data on tx_load with tx_ready=1 and clear tx_ready on the next cycle. tx_load with tx_ready=0 SHALL be ignored, and the buffer SHALL keep its contents.
REQ-025 SHALL give priority to a buffer load (REQ-019/REQ-023) over tx_load in the same cycle; that tx_load is dropped and tx_ready stays 1.
REQ-026 SHALL, on a CSN rise with bit counter != 0, pulse frame_err, discard the partial byte (no rx_valid), and leave the tx buffer untouched.
REQ-027 SHALL ignore SCLK edges in WAIT and IDLE.

Reset
REQ-028 SHALL, while rst_n=0 at a sclk rise, set state=WAIT, SPI_MISO=0, tx_ready=1, tx buffer=0x00, rx_data=0x00, rx_valid=0, frame_err=0, busy=0, counter=0, SCLK synchronizers=0 and CSN synchronizers=1.
REQ-029 SHALL, on reset mid-frame with CSN held low, stay in WAIT until CSN goes high; no rx_valid and no frame_err for that frame.

Verification
REQ-030 SHALL cover: tx_load 0x3C, then one frame with master MOSI 0xA5 -> rx_data=0xA5 with one rx_valid pulse; master reads 0x3C; tx_ready=1 after the CSN fall.
REQ-031 SHALL cover: 16-bit frame, MOSI 0x12,0x34, buffer 0x56 then 0x78 loaded between bytes -> two rx_valid pulses (0x12, 0x34); master reads 0x56,0x78.
REQ-032 SHALL cover: frame with empty tx buffer -> MISO reads 0x00; rx still correct.
REQ-033 SHALL cover: CSN rises after 3 SCLK rises -> one frame_err pulse, no rx_valid, rx_data unchanged.
REQ-034 SHALL cover: tx_load 0x11 then tx_load 0x22 with no frame between -> 0x22 ignored; master reads 0x11.
REQ-035 SHALL cover: rst_n low for 2 cycles mid-byte with CSN low -> state WAIT, MISO=0; a subsequent full frame after CSN high-then-low transfers correctly.
